peak_topk: RTL and testbench

//  Parametrised successor to the fixed-size peak picker. Captures one FFT magnitude frame, scans it
//  one bin per cycle, keeps the NUM_PEAKS largest local maxima at or above a runtime threshold, and

---
 rtl/peak_topk_if.sv | 31 +++
 rtl/peak_topk.sv | 158 +++++++++++++++
 tb/tb_peak_topk.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peak_topk_if.sv
// Frame/result bundle for the top-K peak picker: frame input with ready/drop handshake and
// sorted peak list output.
interface peak_topk_if #(
  parameter int unsigned NUM_BINS  = 16,
  parameter int unsigned NUM_PEAKS = 4,
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH = 16
);
  localparam int unsigned FREQ_WIDTH = $clog2(NUM_BINS);
  localparam int unsigned CNT_WIDTH  = $clog2(NUM_PEAKS + 1);

  logic                                   valid_in;
  logic                                   ready_out;
  logic [NUM_BINS-1:0][IN_WIDTH-1:0]      fft_in;
  logic [IN_WIDTH-1:0]                    threshold;
  logic [NUM_PEAKS-1:0][OUT_WIDTH-1:0]    amplitudes_out;
  logic [NUM_PEAKS-1:0][FREQ_WIDTH-1:0]   freqs_out;
  logic [CNT_WIDTH-1:0]                   num_found;
  logic                                   valid_out;
  logic                                   drop_out;

  modport master (
    output valid_in, fft_in, threshold,
    input  ready_out, amplitudes_out, freqs_out, num_found, valid_out, drop_out
  );

  modport slave (
    input  valid_in, fft_in, threshold,
    output ready_out, amplitudes_out, freqs_out, num_found, valid_out, drop_out
  );
endinterface

// File: rtl/peak_topk.sv
// Top-K local-maximum picker: captures one magnitude frame, scans one bin per cycle and keeps
// the NUM_PEAKS largest qualifying peaks sorted by amplitude (ties keep scan order).
module peak_topk #(
  parameter int unsigned NUM_BINS  = 16,
  parameter int unsigned NUM_PEAKS = 4,
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  peak_topk_if.slave  bus
);
  localparam int unsigned FREQ_WIDTH = $clog2(NUM_BINS);
  localparam int unsigned CNT_WIDTH  = $clog2(NUM_PEAKS + 1);
  localparam logic [FREQ_WIDTH-1:0] LastBin = FREQ_WIDTH'(NUM_BINS - 1);
  localparam logic [CNT_WIDTH-1:0]  MaxCnt  = CNT_WIDTH'(NUM_PEAKS);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e state_q, state_d;

  logic [NUM_BINS-1:0][IN_WIDTH-1:0]     frame_q;
  logic [IN_WIDTH-1:0]                   thr_q;
  logic [FREQ_WIDTH-1:0]                 k_q;
  logic [NUM_PEAKS-1:0][IN_WIDTH-1:0]    list_amp_q, list_amp_d;
  logic [NUM_PEAKS-1:0][FREQ_WIDTH-1:0]  list_freq_q, list_freq_d;
  logic [CNT_WIDTH-1:0]                  list_cnt_q, list_cnt_d;

  logic [NUM_PEAKS-1:0][OUT_WIDTH-1:0]   amp_out_q;
  logic [NUM_PEAKS-1:0][FREQ_WIDTH-1:0]  freq_out_q;
  logic [CNT_WIDTH-1:0]                  cnt_out_q;
  logic                                  valid_q;
  logic                                  drop_q;

  logic                                  capture;
  logic                                  cand_qual;
  logic [IN_WIDTH-1:0]                   cand, prev_amp, next_amp;
  // rank_gt[i+1]: candidate outranks slot i; rank_gt[0] is a constant 0 guard
  logic [NUM_PEAKS:0]                    rank_gt;
  logic [NUM_PEAKS:0][IN_WIDTH-1:0]      ext_amp;
  logic [NUM_PEAKS:0][FREQ_WIDTH-1:0]    ext_freq;

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.ready_out = 1'b0;
    capture       = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.ready_out = 1'b1;
        if (bus.valid_in) begin
          capture = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (k_q == LastBin) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Local-maximum test on bin k; out-of-frame neighbours read as zero
  always_comb begin
    cand     = frame_q[k_q];
    prev_amp = '0;
    next_amp = '0;
    if (k_q != '0) begin
      prev_amp = frame_q[k_q - 1'b1];
    end
    if (k_q != LastBin) begin
      next_amp = frame_q[k_q + 1'b1];
    end
    cand_qual = (state_q == StScan) && (cand > prev_amp) && (cand >= next_amp) &&
                (cand >= thr_q) && (cand != '0);
  end

  // Parallel compare-shift insertion; strict > keeps earlier bins ahead on ties
  always_comb begin
    rank_gt     = '0;
    ext_amp     = {list_amp_q, cand};
    ext_freq    = {list_freq_q, k_q};
    list_amp_d  = list_amp_q;
    list_freq_d = list_freq_q;
    list_cnt_d  = list_cnt_q;
    for (int i = 0; i < NUM_PEAKS; i++) begin
      rank_gt[i+1] = (CNT_WIDTH'(i) >= list_cnt_q) || (cand > list_amp_q[i]);
    end
    if (cand_qual) begin
      for (int i = 0; i < NUM_PEAKS; i++) begin
        if (rank_gt[i+1]) begin
          list_amp_d[i]  = rank_gt[i] ? ext_amp[i] : cand;
          list_freq_d[i] = rank_gt[i] ? ext_freq[i] : k_q;
        end
      end
      if (list_cnt_q != MaxCnt) begin
        list_cnt_d = list_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_q     <= '0;
      thr_q       <= '0;
      k_q         <= '0;
      list_amp_q  <= '0;
      list_freq_q <= '0;
      list_cnt_q  <= '0;
      amp_out_q   <= '0;
      freq_out_q  <= '0;
      cnt_out_q   <= '0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      valid_q <= (state_q == StDone);
      drop_q  <= bus.valid_in && (state_q != StIdle);
      if (capture) begin
        frame_q     <= bus.fft_in;
        thr_q       <= bus.threshold;
        k_q         <= '0;
        list_amp_q  <= '0;
        list_freq_q <= '0;
        list_cnt_q  <= '0;
      end else if (state_q == StScan) begin
        k_q         <= k_q + 1'b1;
        list_amp_q  <= list_amp_d;
        list_freq_q <= list_freq_d;
        list_cnt_q  <= list_cnt_d;
      end
      if (state_q == StDone) begin
        for (int i = 0; i < NUM_PEAKS; i++) begin
          amp_out_q[i] <= list_amp_q[i][IN_WIDTH-1 -: OUT_WIDTH];
        end
        freq_out_q <= list_freq_q;
        cnt_out_q  <= list_cnt_q;
      end
    end
  end

  assign bus.amplitudes_out = amp_out_q;
  assign bus.freqs_out      = freq_out_q;
  assign bus.num_found      = cnt_out_q;
  assign bus.valid_out      = valid_q;
  assign bus.drop_out       = drop_q;

endmodule

// File: tb/tb_peak_topk.sv
// Scoreboard bench for peak_topk: a narrow 8/8 instance for the functional vectors and a
// 24/16 instance for output truncation.
module tb_peak_topk;
  typedef struct packed {
    logic [3:0][7:0] amps;
    logic [3:0][3:0] freqs;
    logic [2:0]      n;
    logic [31:0]     due;
  } exp_t;

  typedef struct packed {
    logic [3:0][15:0] amps;
    logic [3:0][3:0]  freqs;
    logic [2:0]       n;
    logic [31:0]      due;
  } exp2_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails = 0;
  int vcount = 0;
  int dcount = 0;
  int npush = 0;

  exp_t  q[$];
  exp2_t q2[$];
  exp_t  e;
  exp2_t e2;

  peak_topk_if #(.NUM_BINS(16), .NUM_PEAKS(4), .IN_WIDTH(8),  .OUT_WIDTH(8))  bus ();
  peak_topk_if #(.NUM_BINS(16), .NUM_PEAKS(4), .IN_WIDTH(24), .OUT_WIDTH(16)) bus2 ();

  peak_topk #(.NUM_BINS(16), .NUM_PEAKS(4), .IN_WIDTH(8), .OUT_WIDTH(8)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  peak_topk #(.NUM_BINS(16), .NUM_PEAKS(4), .IN_WIDTH(24), .OUT_WIDTH(16)) dut2 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus2.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0][7:0] a4(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [3:0][3:0] f4(input logic [3:0] f0, f1, f2, f3);
    return {f3, f2, f1, f0};
  endfunction

  // Called at the negedge before the capture edge; result due 17 cycles after capture
  task automatic push_exp(input logic [3:0][7:0] ea, input logic [3:0][3:0] ef,
                          input logic [2:0] en);
    exp_t x;
    x.amps  = ea;
    x.freqs = ef;
    x.n     = en;
    x.due   = cyc + 18;
    q.push_back(x);
    npush++;
  endtask

  task automatic send(input logic [15:0][7:0] f, input logic [7:0] thr, input bit push,
                      input logic [3:0][7:0] ea, input logic [3:0][3:0] ef,
                      input logic [2:0] en);
    @(negedge clk);
    bus.fft_in    = f;
    bus.threshold = thr;
    bus.valid_in  = 1'b1;
    if (push) push_exp(ea, ef, en);
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_q(input bit second);
    for (int i = 0; i < 60; i++) begin
      if ((second ? q2.size() : q.size()) == 0) break;
      @(negedge clk);
    end
    checks++;
    if ((second ? q2.size() : q.size()) != 0) begin
      fails++;
      $display("FAIL result_timeout: got=no valid_out expected=valid_out (cycle %0d)", cyc);
      if (second) q2.delete(); else q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid_out) begin
      vcount++;
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got=valid_out expected=none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("amplitudes", bus.amplitudes_out, e.amps);
        chk("freqs", bus.freqs_out, e.freqs);
        chk("num_found", bus.num_found, e.n);
        chk("latency", cyc, e.due);
      end
    end
    if (bus.drop_out) dcount++;
  end

  always @(negedge clk) begin
    if (bus2.valid_out) begin
      if (q2.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid2: got=valid_out expected=none (cycle %0d)", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("amplitudes_w", bus2.amplitudes_out, e2.amps);
        chk("freqs_w", bus2.freqs_out, e2.freqs);
        chk("num_found_w", bus2.num_found, e2.n);
        chk("latency_w", cyc, e2.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0][7:0]  f;
    logic [15:0][7:0]  fa;
    logic [15:0][23:0] fw;
    exp2_t             x2;
    bit                seen;

    bus.valid_in   = 1'b0;
    bus.fft_in     = '0;
    bus.threshold  = '0;
    bus2.valid_in  = 1'b0;
    bus2.fft_in    = '0;
    bus2.threshold = '0;

    // Reset, then idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.ready_out, 1'b1);
    chk("rst_amps", bus.amplitudes_out, '0);
    chk("rst_freqs", bus.freqs_out, '0);
    chk("rst_num", bus.num_found, '0);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_drop", bus.drop_out, 1'b0);
    repeat (20) @(negedge clk);

    // Basic frame at two thresholds
    f = '0;
    f[0] = 1; f[1] = 2; f[2] = 3; f[3] = 4; f[4] = 5; f[5] = 4; f[6] = 7; f[8] = 8; f[13] = 1;
    send(f, 8'd1, 1'b1, a4(8, 7, 5, 1), f4(8, 6, 4, 13), 3'd4);
    wait_q(1'b0);
    send(f, 8'd2, 1'b1, a4(8, 7, 5, 0), f4(8, 6, 4, 0), 3'd3);
    wait_q(1'b0);

    // Equal peaks and a plateau; threshold equal to a peak still qualifies
    f = '0;
    f[2] = 6; f[9] = 6; f[12] = 5; f[13] = 5;
    send(f, 8'd1, 1'b1, a4(6, 6, 5, 0), f4(2, 9, 12, 0), 3'd3);
    wait_q(1'b0);
    send(f, 8'd5, 1'b1, a4(6, 6, 5, 0), f4(2, 9, 12, 0), 3'd3);
    wait_q(1'b0);
    send(f, 8'd6, 1'b1, a4(6, 6, 0, 0), f4(2, 9, 0, 0), 3'd2);
    wait_q(1'b0);

    // All-zero frame
    f = '0;
    send(f, 8'd0, 1'b1, a4(0, 0, 0, 0), f4(0, 0, 0, 0), 3'd0);
    wait_q(1'b0);

    // Six maxima into a 4-deep list; threshold above all peaks
    fa = '0;
    fa[0] = 9; fa[2] = 3; fa[4] = 8; fa[6] = 1; fa[8] = 7; fa[10] = 5;
    send(fa, 8'd1, 1'b1, a4(9, 8, 7, 5), f4(0, 4, 8, 10), 3'd4);
    wait_q(1'b0);
    send(fa, 8'd10, 1'b1, a4(0, 0, 0, 0), f4(0, 0, 0, 0), 3'd0);
    wait_q(1'b0);

    // Peak on the last bin
    f = '0;
    f[14] = 2; f[15] = 3;
    send(f, 8'd1, 1'b1, a4(3, 0, 0, 0), f4(15, 0, 0, 0), 3'd1);
    wait_q(1'b0);

    // Five equal peaks: earliest four kept in scan order
    f = '0;
    f[1] = 4; f[3] = 4; f[5] = 4; f[7] = 4; f[9] = 4;
    send(f, 8'd1, 1'b1, a4(4, 4, 4, 4), f4(1, 3, 5, 7), 3'd4);
    wait_q(1'b0);

    // Busy drop, then back-to-back accept in the valid_out cycle
    send(fa, 8'd1, 1'b1, a4(9, 8, 7, 5), f4(0, 4, 8, 10), 3'd4);
    repeat (4) @(negedge clk);
    chk("busy_ready", bus.ready_out, 1'b0);
    f = '0;
    f[3] = 200;
    bus.fft_in   = f;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    chk("drop_pulse", bus.drop_out, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk("first_result_seen", seen, 1'b1);
    chk("done_ready", bus.ready_out, 1'b1);
    f = '0;
    f[2] = 6; f[9] = 6; f[12] = 5; f[13] = 5;
    bus.fft_in    = f;
    bus.threshold = 8'd1;
    bus.valid_in  = 1'b1;
    push_exp(a4(6, 6, 5, 0), f4(2, 9, 12, 0), 3'd3);
    @(negedge clk);
    bus.valid_in = 1'b0;
    wait_q(1'b0);

    // Reset 8 cycles into a scan aborts it
    send(fa, 8'd1, 1'b0, a4(0, 0, 0, 0), f4(0, 0, 0, 0), 3'd0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", bus.ready_out, 1'b1);
    chk("abort_amps", bus.amplitudes_out, '0);
    chk("abort_freqs", bus.freqs_out, '0);
    chk("abort_num", bus.num_found, '0);
    repeat (20) @(negedge clk);
    f = '0;
    f[0] = 1; f[1] = 2; f[2] = 3; f[3] = 4; f[4] = 5; f[5] = 4; f[6] = 7; f[8] = 8; f[13] = 1;
    send(f, 8'd1, 1'b1, a4(8, 7, 5, 1), f4(8, 6, 4, 13), 3'd4);
    wait_q(1'b0);

    // Wide instance: output keeps the top 16 of 24 bits
    fw = '0;
    fw[5] = 24'h123456;
    @(negedge clk);
    bus2.fft_in    = fw;
    bus2.threshold = 24'd1;
    bus2.valid_in  = 1'b1;
    x2.amps  = {16'h0, 16'h0, 16'h0, 16'h1234};
    x2.freqs = f4(5, 0, 0, 0);
    x2.n     = 3'd1;
    x2.due   = cyc + 18;
    q2.push_back(x2);
    @(negedge clk);
    bus2.valid_in = 1'b0;
    wait_q(1'b1);

    repeat (3) @(negedge clk);
    chk("valid_pulses", 64'(vcount), 64'(npush));
    chk("drop_pulses", 64'(dcount), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
